// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the oversampling UART receiver.
//   OsRate   - oversample ticks per bit
//   parity_e - parity selection (none / odd / even)
//   state_e  - receiver FSM states; StBreak exists only with UART_RX_BREAK_DET_EN defined
package uart_pkg;

    localparam int unsigned OsRate = 16;

    typedef enum logic [1:0] {
        ParNone = 2'd0,
        ParOdd  = 2'd1,
        ParEven = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
`ifdef UART_RX_BREAK_DET_EN
        , StBreak
`endif
    } state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversample tick generator, one tick every Div clocks.
//   clk_i     - clock
//   rst_i     - synchronous active-high reset
//   restart_i - zero the phase counter; the first tick follows Div clocks later
//   tick_o    - single-cycle oversample tick
module uart_baud_gen #(
    parameter int unsigned Div = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] Last = CntW'(Div - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = !restart_i && (cnt_q == Last);
        cnt_d  = (restart_i || tick_o) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampling UART receiver with a one-word holding register.
//   clk, rst      - clock, synchronous active-high reset
//   rx            - asynchronous serial input, idle high
//   rx_data_out   - received word (LSB = first data bit), valid while rx_data_vld
//   rx_data_vld   - holding register full; rx_data_rdy accepts it
//   rx_parity_err - parity error of the held word
//   rx_frame_err  - a stop bit of the held word sampled 0
//   rx_overrun    - one-cycle pulse when a finished frame is dropped
//   rx_break      - one-cycle pulse on break detection (UART_RX_BREAK_DET_EN), else 0
//   rx_busy       - receiver FSM not idle
// Define UART_RX_BREAK_DET_EN to enable break detection.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned clk_freq    = 50000000,
    parameter int unsigned baud_rate   = 19200,
    parameter int unsigned data_bits   = 8,
    parameter int unsigned parity_type = 0,
    parameter int unsigned stop_bits   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [data_bits-1:0] rx_data_out,
    output logic                 rx_data_vld,
    input  logic                 rx_data_rdy,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_break,
    output logic                 rx_busy
);

    if (data_bits < 5 || data_bits > 9) begin : g_bad_data_bits
        $error("uart_rx_os: data_bits must be 5..9");
    end
    if (parity_type > 2) begin : g_bad_parity
        $error("uart_rx_os: parity_type must be 0..2");
    end
    if (stop_bits < 1 || stop_bits > 2) begin : g_bad_stop_bits
        $error("uart_rx_os: stop_bits must be 1..2");
    end

    localparam int unsigned DivRaw = (clk_freq + (OsRate * baud_rate) / 2) / (OsRate * baud_rate);
    localparam int unsigned Div    = (DivRaw == 0) ? 1 : DivRaw;
    localparam parity_e     Par    = parity_e'(parity_type[1:0]);

    logic rx_meta_q, rx_sync_q, rx_prev_q;
    logic tick, restart, fall, bit_val, load;

    state_e               state_q, state_d;
    logic [3:0]           samp_q, samp_d;      // ticks into current bit; break: high-tick run
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 s7_q, s7_d, s8_q, s8_d;
    logic [data_bits-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d, frm_err_q, frm_err_d;
    logic                 done_q, done_d;

    logic [data_bits-1:0] hold_data_q;
    logic                 vld_q, hold_pe_q, hold_fe_q, ovr_q;

`ifdef UART_RX_BREAK_DET_EN
    logic par_bit_q, par_bit_d, brk_q, brk_d;
`endif

    uart_baud_gen #(
        .Div (Div)
    ) u_baud_gen (
        .clk_i     (clk),
        .rst_i     (rst),
        .restart_i (restart),
        .tick_o    (tick)
    );

    assign fall    = rx_prev_q && !rx_sync_q;
    assign bit_val = (s7_q & s8_q) | (s7_q & rx_sync_q) | (s8_q & rx_sync_q);

    always_comb begin
        state_d   = state_q;
        samp_d    = samp_q;
        bit_cnt_d = bit_cnt_q;
        s7_d      = s7_q;
        s8_d      = s8_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        done_d    = 1'b0;
        restart   = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        par_bit_d = par_bit_q;
        brk_d     = 1'b0;
`endif
        if (state_q == StIdle) begin
            if (fall) begin
                state_d   = StStart;
                samp_d    = '0;
                bit_cnt_d = '0;
                par_err_d = 1'b0;
                frm_err_d = 1'b0;
                restart   = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                par_bit_d = 1'b0;
`endif
            end
`ifdef UART_RX_BREAK_DET_EN
        end else if (state_q == StBreak) begin
            // Leave only after 16 consecutive high ticks.
            if (tick) begin
                if (!rx_sync_q) begin
                    samp_d = '0;
                end else if (samp_q == 4'd15) begin
                    samp_d  = '0;
                    state_d = StIdle;
                end else begin
                    samp_d = samp_q + 4'd1;
                end
            end
`endif
        end else if (tick) begin
            samp_d = samp_q + 4'd1;   // wraps 15->0 at the bit boundary
            if (samp_q == 4'd6) s7_d = rx_sync_q;
            if (samp_q == 4'd7) s8_d = rx_sync_q;
            // Sample 9: state names the bit being decided now.
            if (samp_q == 4'd8) begin
                unique case (state_q)
                    StStart: state_d = bit_val ? StIdle : StData;
                    StData: begin
                        shift_d = {bit_val, shift_q[data_bits-1:1]};
                        if (bit_cnt_q == 4'(data_bits - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = (Par != ParNone) ? StParity : StStop;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                    StParity: begin
                        // ^shift_q ^ bit_val is 1 when the total count of ones is odd.
                        par_err_d = (Par == ParOdd) ? ~(^shift_q ^ bit_val)
                                                    : (^shift_q ^ bit_val);
                        state_d   = StStop;
`ifdef UART_RX_BREAK_DET_EN
                        par_bit_d = bit_val;
`endif
                    end
                    StStop: begin
                        frm_err_d = frm_err_q | ~bit_val;
`ifdef UART_RX_BREAK_DET_EN
                        if (bit_cnt_q == '0 && shift_q == '0 && !bit_val &&
                            (Par == ParNone || !par_bit_q)) begin
                            state_d = StBreak;
                            samp_d  = '0;
                            brk_d   = 1'b1;
                        end else
`endif
                        if (bit_cnt_q == 4'(stop_bits - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = StIdle;
                            done_d    = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // A finished frame is taken if the register is empty or being drained this cycle.
    assign load = done_q && (!vld_q || rx_data_rdy);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= StIdle;
            samp_q      <= '0;
            bit_cnt_q   <= '0;
            s7_q        <= 1'b0;
            s8_q        <= 1'b0;
            shift_q     <= '0;
            par_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            done_q      <= 1'b0;
            vld_q       <= 1'b0;
            hold_data_q <= '0;
            hold_pe_q   <= 1'b0;
            hold_fe_q   <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            samp_q    <= samp_d;
            bit_cnt_q <= bit_cnt_d;
            s7_q      <= s7_d;
            s8_q      <= s8_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            done_q    <= done_d;
            ovr_q     <= done_q && !load;
            if (load) begin
                vld_q       <= 1'b1;
                hold_data_q <= shift_q;
                hold_pe_q   <= par_err_q;
                hold_fe_q   <= frm_err_q;
            end else if (vld_q && rx_data_rdy) begin
                vld_q       <= 1'b0;
                hold_data_q <= '0;
                hold_pe_q   <= 1'b0;
                hold_fe_q   <= 1'b0;
            end
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit_q <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            par_bit_q <= par_bit_d;
            brk_q     <= brk_d;
        end
    end
    assign rx_break = brk_q;
`else
    assign rx_break = 1'b0;
`endif

    assign rx_data_out   = hold_data_q;
    assign rx_data_vld   = vld_q;
    assign rx_parity_err = hold_pe_q;
    assign rx_frame_err  = hold_fe_q;
    assign rx_overrun    = ovr_q;
    assign rx_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: three receivers (8N1, 8E1, 8N2) at 16 clocks per bit, driven
// from a frame table; a negedge monitor pops expected words from per-receiver queues.
module tb_uart_rx_os;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rdy = 1'b1;
    logic [2:0] rx_l = 3'b111;

    logic [7:0] dout [3];
    logic [2:0] vld, pe, fe, ovr, brk, busy;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int ovr_cnt [3] = '{0, 0, 0};
    int brk_cnt [3] = '{0, 0, 0};
    int last_xfer [3] = '{0, 0, 0};
    int start_cyc [3] = '{0, 0, 0};

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;
    exp_t q0[$], q1[$], q2[$];

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic       pb;
        logic       s1;
        logic       s2;
        logic       pe;
        logic       fe;
    } vec_t;
    vec_t vecs [12];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_os #(.clk_freq(16000000), .baud_rate(1000000), .data_bits(8),
                 .parity_type(0), .stop_bits(1)) u_n1 (
        .clk(clk), .rst(rst), .rx(rx_l[0]), .rx_data_out(dout[0]), .rx_data_vld(vld[0]),
        .rx_data_rdy(rdy), .rx_parity_err(pe[0]), .rx_frame_err(fe[0]),
        .rx_overrun(ovr[0]), .rx_break(brk[0]), .rx_busy(busy[0]));

    uart_rx_os #(.clk_freq(16000000), .baud_rate(1000000), .data_bits(8),
                 .parity_type(2), .stop_bits(1)) u_e1 (
        .clk(clk), .rst(rst), .rx(rx_l[1]), .rx_data_out(dout[1]), .rx_data_vld(vld[1]),
        .rx_data_rdy(rdy), .rx_parity_err(pe[1]), .rx_frame_err(fe[1]),
        .rx_overrun(ovr[1]), .rx_break(brk[1]), .rx_busy(busy[1]));

    uart_rx_os #(.clk_freq(16000000), .baud_rate(1000000), .data_bits(8),
                 .parity_type(0), .stop_bits(2)) u_n2 (
        .clk(clk), .rst(rst), .rx(rx_l[2]), .rx_data_out(dout[2]), .rx_data_vld(vld[2]),
        .rx_data_rdy(rdy), .rx_parity_err(pe[2]), .rx_frame_err(fe[2]),
        .rx_overrun(ovr[2]), .rx_break(brk[2]), .rx_busy(busy[2]));

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic p, input logic f);
        exp_t e;
        e.d = d; e.pe = p; e.fe = f;
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic pop_check(input int i);
        exp_t e;
        if (qsize(i) == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_xfer[%0d]: got data 0x%0h, expected no word", i, dout[i]);
            return;
        end
        case (i)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        chk($sformatf("data[%0d]", i), int'(dout[i]), int'(e.d));
        chk($sformatf("parity_err[%0d]", i), int'(pe[i]), int'(e.pe));
        chk($sformatf("frame_err[%0d]", i), int'(fe[i]), int'(e.fe));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (vld[i] && rdy) begin
                    last_xfer[i] = cyc;
                    pop_check(i);
                end
                if (ovr[i]) ovr_cnt[i]++;
                if (brk[i]) brk_cnt[i]++;
            end
        end
    end

    task automatic send_bit(input int i, input logic v);
        rx_l[i] = v;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int i, input logic [7:0] d, input logic pb,
                              input logic s1, input logic s2);
        @(posedge clk);
        #1;
        start_cyc[i] = cyc;
        send_bit(i, 1'b0);
        for (int b = 0; b < 8; b++) send_bit(i, d[b]);
        if (i == 1) send_bit(i, pb);
        send_bit(i, s1);
        if (i == 2) send_bit(i, s2);
        send_bit(i, 1'b1);
        send_bit(i, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int ovr0;
        int brk0;
        vecs[0]  = '{0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1, 8'h0F, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{2, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{2, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{2, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{2, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset state.
        repeat (4) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_vld[%0d]", i), int'(vld[i]), 0);
            chk($sformatf("rst_data[%0d]", i), int'(dout[i]), 0);
            chk($sformatf("rst_flags[%0d]", i), int'({pe[i], fe[i], ovr[i], brk[i]}), 0);
            chk($sformatf("rst_busy[%0d]", i), int'(busy[i]), 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        for (int v = 0; v < 12; v++) begin
            push(vecs[v].inst, vecs[v].data, vecs[v].pe, vecs[v].fe);
            send_frame(vecs[v].inst, vecs[v].data, vecs[v].pb, vecs[v].s1, vecs[v].s2);
        end

        // 8N1 latency: rx falls after posedge 0; sync adds 2, edge registered at 3, start
        // decision at 3+9, stop decision 9 bits later, load one cycle after -> 157.
        push(0, 8'hA5, 1'b0, 1'b0);
        send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1);
        chk("latency_8n1", last_xfer[0] - start_cyc[0], 157);

        // Overrun: second frame dropped while the first is held.
        ovr0 = ovr_cnt[0];
        rdy = 1'b0;
        push(0, 8'h11, 1'b0, 1'b0);
        send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("ovr_vld_held", int'(vld[0]), 1);
        chk("ovr_data_held", int'(dout[0]), 8'h11);
        chk("ovr_pulses", ovr_cnt[0] - ovr0, 1);
        @(posedge clk);
        #1 rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ovr_vld_drop", int'(vld[0]), 0);
        chk("ovr_data_clear", int'(dout[0]), 0);

        // False start: 4 clocks low.
        @(posedge clk);
        #1 rx_l[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx_l[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("false_start_busy", int'(busy[0]), 1);
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("false_start_idle", int'(busy[0]), 0);
        chk("false_start_novld", int'(vld[0]), 0);

        // Break: 20 bit-times low.
        brk0 = brk_cnt[0];
`ifndef UART_RX_BREAK_DET_EN
        push(0, 8'h00, 1'b0, 1'b1);
`endif
        @(posedge clk);
        #1 rx_l[0] = 1'b0;
        repeat (320) @(posedge clk);
        #1 rx_l[0] = 1'b1;
        repeat (64) @(posedge clk);
        @(negedge clk);
        chk("break_idle", int'(busy[0]), 0);
`ifdef UART_RX_BREAK_DET_EN
        chk("break_pulses", brk_cnt[0] - brk0, 1);
`else
        chk("break_pulses", brk_cnt[0] - brk0, 0);
`endif
        chk("break_queue", qsize(0), 0);

        // Mid-frame reset: nothing from the interrupted frame may appear.
        @(posedge clk);
        #1;
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        rst = 1'b1;
        rx_l[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", int'(busy[0]), 0);
        chk("midrst_outs", int'({vld[0], pe[0], fe[0], ovr[0], brk[0]}), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (200) @(posedge clk);
        @(negedge clk);
        chk("midrst_idle", int'(busy[0]), 0);
        chk("midrst_novld", int'(vld[0]), 0);

        chk("final_ovr0", ovr_cnt[0], 1);
        chk("final_ovr12", ovr_cnt[1] + ovr_cnt[2], 0);
        for (int i = 0; i < 3; i++) chk($sformatf("final_queue[%0d]", i), qsize(i), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
